// File: rtl/morse_tx_sequencer_if.sv
// rtl/morse_tx_sequencer_if.sv - character handshake bundle for the Morse transmit sequencer
//
// Purpose: groups the character-source handshake into one port.
// Signals:
//   char_data  [7:0] ASCII character from the source
//   char_valid       char_data is valid
//   char_ready       sequencer accepts a character this cycle
// Modports: master = character source, slave = sequencer.

interface morse_tx_sequencer_if;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/morse_tx_sequencer.sv
// rtl/morse_tx_sequencer.sv - Morse transmit sequencer driving an external Encoder
//
// Purpose: accepts ASCII characters, presents each to the Encoder, captures the
// 40-bit MSB-first key pattern and plays it out on key_out with unit timing,
// followed by an inter-character gap (or a word gap for a space).
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   chr        character handshake (char_data / char_valid / char_ready)
//   enc_char   character driven to the Encoder
//   enc_code   Encoder result, left-aligned key pattern, zero-padded
//   key_out    keying output
//   busy       sequencer active (and, with the FIFO, characters queued)
//   err        one-cycle pulse when the Encoder returns an empty pattern
// Build option: MORSE_TX_FIFO_EN adds a 4-entry input FIFO in front of IDLE.

module morse_tx_sequencer #(
  parameter int UNIT_CYCLES = 4,
  parameter int ENC_LATENCY = 1,
  parameter int CHAR_GAP    = 3,
  parameter int WORD_EXTRA  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  morse_tx_sequencer_if.slave  chr,
  output logic [7:0]           enc_char,
  input  logic [39:0]          enc_code,
  output logic                 key_out,
  output logic                 busy,
  output logic                 err
);

  localparam int UW   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int LW   = $clog2(ENC_LATENCY + 1);
  localparam int GMAX = (CHAR_GAP > WORD_EXTRA) ? CHAR_GAP : WORD_EXTRA;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t        state, state_n;
  logic [7:0]    enc_char_n;
  logic [39:0]   shreg, shreg_n, shifted;
  logic [LW-1:0] lat_cnt, lat_n;
  logic [UW-1:0] unit_cnt, unit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          err_n;
  logic          run;       // low only until the first edge after reset, keeps char_ready at 0 in reset
  logic          take;      // IDLE accepts a character this cycle
  logic [7:0]    take_data;
  logic          unit_end;

`ifdef MORSE_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push;

  assign chr.char_ready = run & (count != 3'd4);
  assign push           = chr.char_valid & chr.char_ready;
  // A push into an empty FIFO is only visible next cycle, so it is never popped the same cycle.
  assign take           = (state == IDLE) & (count != 3'd0);
  assign take_data      = fifo_mem[rd_ptr];
  assign busy           = (state != IDLE) | (count != 3'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= chr.char_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (take) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, take};
    end
  end
`else
  assign chr.char_ready = run & (state == IDLE);
  assign take           = chr.char_valid & chr.char_ready;
  assign take_data      = chr.char_data;
  assign busy           = (state != IDLE);
`endif

  assign key_out  = (state == SEND) & shreg[39];
  assign unit_end = (unit_cnt == UW'(UNIT_CYCLES - 1));
  assign shifted  = {shreg[38:0], 1'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      enc_char <= 8'h00;
      shreg    <= '0;
      lat_cnt  <= '0;
      unit_cnt <= '0;
      gap_cnt  <= '0;
      err      <= 1'b0;
      run      <= 1'b0;
    end else begin
      state    <= state_n;
      enc_char <= enc_char_n;
      shreg    <= shreg_n;
      lat_cnt  <= lat_n;
      unit_cnt <= unit_n;
      gap_cnt  <= gap_n;
      err      <= err_n;
      run      <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    enc_char_n = enc_char;
    shreg_n    = shreg;
    lat_n      = lat_cnt;
    unit_n     = unit_cnt;
    gap_n      = gap_cnt;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          enc_char_n = take_data;
          lat_n      = '0;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        if (lat_cnt == LW'(ENC_LATENCY)) begin
          unit_n = '0;
          if (enc_char == 8'h20) begin
            gap_n   = GW'(WORD_EXTRA);
            state_n = (WORD_EXTRA == 0) ? IDLE : GAP;
          end else if (enc_code == 40'd0) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            shreg_n = enc_code;
            state_n = SEND;
          end
        end else begin
          lat_n = lat_cnt + LW'(1);
        end
      end
      SEND: begin
        if (unit_end) begin
          unit_n  = '0;
          shreg_n = shifted;
          // Trailing zeros of the pattern are replaced by the character gap.
          if (shifted == 40'd0) begin
            gap_n   = GW'(CHAR_GAP);
            state_n = (CHAR_GAP == 0) ? IDLE : GAP;
          end
        end else begin
          unit_n = unit_cnt + UW'(1);
        end
      end
      GAP: begin
        if (unit_end) begin
          unit_n = '0;
          if (gap_cnt <= GW'(1)) state_n = IDLE;
          else                   gap_n   = gap_cnt - GW'(1);
        end else begin
          unit_n = unit_cnt + UW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// tb/tb_morse_tx_sequencer.sv - self-checking bench for morse_tx_sequencer

module tb_morse_tx_sequencer;

  logic        clock;
  logic        reset_n;
  logic [7:0]  enc_char;
  logic [39:0] enc_code;
  logic        key_out;
  logic        busy;
  logic        err;

  morse_tx_sequencer_if cif ();

  morse_tx_sequencer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .chr      (cif),
    .enc_char (enc_char),
    .enc_code (enc_code),
    .key_out  (key_out),
    .busy     (busy),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Encoder model: one registered lookup stage.
  always @(posedge clock) begin
    case (enc_char)
      8'h45:   enc_code <= 40'h80_0000_0000;  // E  .
      8'h54:   enc_code <= 40'hE0_0000_0000;  // T  -
      8'h41:   enc_code <= 40'hB8_0000_0000;  // A  .-
      default: enc_code <= 40'h00_0000_0000;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Character source: delivers src_q[0..src_n-1] in order, valid held until each is taken.
  logic [7:0] src_q [2];
  int         src_n;
  int         src_idx;

  task automatic src_advance();
    src_idx++;
    if (src_idx < src_n) cif.char_data = src_q[src_idx];
    else                 cif.char_valid = 1'b0;
  endtask

  task automatic step();
    logic p;
    p = cif.char_valid && cif.char_ready;
    @(negedge clock);
    if (p) src_advance();
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 200; i++) begin
      if (cif.char_ready) break;
      @(negedge clock);
    end
    chk({name, "_ready_wait"}, cif.char_ready, 1);
  endtask

  // Sends n characters, then records key_out from the first possible key cycle
  // (acceptance edge + ENC_LATENCY + 1) for len cycles; trace bit 63 = first cycle.
  task automatic play(input string name, input logic [7:0] c0, input logic [7:0] c1, input int n,
                      input logic [63:0] exp_trace, input int len, input logic exp_err,
                      input logic chk_busy);
    logic [63:0] act;
    logic        bz_ok;
    src_q[0] = c0;
    src_q[1] = c1;
    src_n    = n;
    src_idx  = 0;
    wait_ready(name);
    cif.char_data  = c0;
    cif.char_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    src_advance();
    step();
    step();
    chk({name, "_err"}, err, exp_err);
    chk({name, "_enc_char"}, enc_char, c0);
    act   = '0;
    bz_ok = 1'b1;
    for (int k = 0; k < len; k++) begin
      act[63-k] = key_out;
      if (!busy) bz_ok = 1'b0;
      step();
    end
    chk({name, "_key_trace"}, act, exp_trace);
    if (chk_busy) chk({name, "_busy_during"}, bz_ok, 1);
    chk({name, "_ready_after"}, cif.char_ready, 1);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_all_taken"}, src_idx, n);
    step();
    chk({name, "_err_after"}, err, 0);
    chk({name, "_key_after"}, key_out, 0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  ch;
    logic [63:0] trace;
    int          len;
    logic        err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"E",     8'h45, 64'hF000_0000_0000_0000, 16, 1'b0};
    vecs[1] = '{"T",     8'h54, 64'hFFF0_0000_0000_0000, 24, 1'b0};
    vecs[2] = '{"A",     8'h41, 64'hF0FF_F000_0000_0000, 32, 1'b0};
    vecs[3] = '{"space", 8'h20, 64'h0000_0000_0000_0000, 16, 1'b0};
    vecs[4] = '{"hash",  8'h23, 64'h0000_0000_0000_0000,  0, 1'b1};

    // Reset with a character already offered.
    reset_n        = 1'b0;
    cif.char_valid = 1'b1;
    cif.char_data  = 8'h45;
    repeat (3) @(negedge clock);
    chk("rst_ready", cif.char_ready, 0);
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enc_char", enc_char, 8'h00);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel_ready", cif.char_ready, 1);
    chk("rel_no_accept_enc", enc_char, 8'h00);
    chk("rel_no_accept_busy", busy, 0);
    cif.char_valid = 1'b0;

    for (int i = 0; i < 5; i++)
      play(vecs[i].name, vecs[i].ch, 8'h00, 1, vecs[i].trace, vecs[i].len, vecs[i].err, 1'b1);

    // T immediately followed by E, valid held across both.
    play("T_then_E", 8'h54, 8'h45, 2, 64'hFFF0_001E_0000_0000, 43, 1'b0, 1'b0);

    // Reset while T is keying; an E offered meanwhile may be queued but must be flushed.
    src_n   = 1;
    src_idx = 0;
    wait_ready("rst_mid");
    cif.char_data  = 8'h54;
    cif.char_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cif.char_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    cif.char_data  = 8'h45;
    cif.char_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      logic p;
      p = cif.char_ready;
      @(negedge clock);
      if (p) cif.char_valid = 1'b0;
    end
    cif.char_valid = 1'b0;
    chk("rst_mid_key_before", key_out, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_key_async", key_out, 0);
    chk("rst_mid_busy_async", busy, 0);
    chk("rst_mid_ready_async", cif.char_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_mid_busy_after", busy, 0);
    chk("rst_mid_key_after", key_out, 0);
    chk("rst_mid_enc_char", enc_char, 8'h00);

    play("E_after_rst", 8'h45, 8'h00, 1, 64'hF000_0000_0000_0000, 16, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
